// File: rtl/fifo_ptr_pkg.sv
// Shared pointer helpers for the dual-clock FIFO read and write sides.
package fifo_ptr_pkg;

  // Widest pointer the helpers handle; callers zero-extend and truncate.
  localparam int unsigned PTR_MAX_W = 32;

  // Pointer width for a given memory address width (one extra wrap bit).
  function automatic int unsigned PTR_W(input int unsigned addrsize);
    return addrsize + 1;
  endfunction

  // Binary to Gray; zero-extension leaves the low bits unchanged.
  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return (b >> 1) ^ b;
  endfunction

  // Gray to binary by XOR prefix from the MSB; upper zero bits are neutral.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b = '0;
    for (int unsigned i = 0; i < PTR_MAX_W; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/rd_ptr_status_gray2bin.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB down).
module gray2bin #(
  parameter int unsigned WIDTH = 5
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  // Each binary bit is the parity of the Gray bits at and above it.
  always_comb begin
    o_bin = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      o_bin[i] = ^(i_gray >> i);
    end
  end

endmodule

// File: rtl/rd_ptr_status.sv
// Read-side pointer and status block for the dual-clock FIFO: binary/Gray
// read pointers, registered empty/almost-empty flags, read-domain level,
// read-accept pulse and sticky underflow flag.
module rd_ptr_status
  import fifo_ptr_pkg::*;
#(
  parameter int unsigned ADDRSIZE = 4
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  rd_en,
  input  logic [ADDRSIZE:0]     rq2_wr_ptr,
  input  logic [ADDRSIZE:0]     rd_ae_thresh,
  input  logic                  rd_underflow_clr,
  output logic [ADDRSIZE-1:0]   rd_addr,
  output logic [ADDRSIZE:0]     rd_grayptr,
  output logic                  rd_empty,
  output logic                  rd_almost_empty,
  output logic [ADDRSIZE:0]     rd_level,
  output logic                  rd_ack,
  output logic                  rd_underflow
);

  localparam int unsigned PW = PTR_W(ADDRSIZE);

  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_rd_grayptr;
  logic          r_rd_empty;
  logic          r_rd_almost_empty;
  logic [PW-1:0] r_rd_level;
  logic          r_rd_ack;
  logic          r_rd_underflow;

  logic          w_accept;
  logic [PW-1:0] w_rd_ptr_next;
  logic [PW-1:0] w_rd_gray_next;
  logic [PW-1:0] w_wr_bin;
  logic [PW-1:0] w_level_next;

  gray2bin #(.WIDTH(PW)) u_wr_gray2bin (
    .i_gray (rq2_wr_ptr),
    .o_bin  (w_wr_bin)
  );

  // Next-pointer, level and accept computation from the current registered state.
  always_comb begin
    w_accept       = rd_en & ~r_rd_empty;
    w_rd_ptr_next  = r_rd_ptr + PW'(w_accept);
    w_rd_gray_next = PW'(bin2gray(PTR_MAX_W'(w_rd_ptr_next)));
    // Flags use the post-read pointer so empty asserts with the last read.
    w_level_next   = w_wr_bin - w_rd_ptr_next;
  end

  // Pointer, flag, level, ack and sticky-underflow registers.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_rd_ptr          <= '0;
      r_rd_grayptr      <= '0;
      r_rd_empty        <= 1'b1;
      r_rd_almost_empty <= 1'b1;
      r_rd_level        <= '0;
      r_rd_ack          <= 1'b0;
      r_rd_underflow    <= 1'b0;
    end else begin
      r_rd_ptr          <= w_rd_ptr_next;
      r_rd_grayptr      <= w_rd_gray_next;
      r_rd_empty        <= (w_rd_gray_next == rq2_wr_ptr);
      r_rd_almost_empty <= (w_level_next <= rd_ae_thresh);
      r_rd_level        <= w_level_next;
      r_rd_ack          <= w_accept;
      if (rd_en && r_rd_empty) begin
        r_rd_underflow <= 1'b1;
      end else if (rd_underflow_clr) begin
        r_rd_underflow <= 1'b0;
      end
    end
  end

  assign rd_addr         = r_rd_ptr[ADDRSIZE-1:0];
  assign rd_grayptr      = r_rd_grayptr;
  assign rd_empty        = r_rd_empty;
  assign rd_almost_empty = r_rd_almost_empty;
  assign rd_level        = r_rd_level;
  assign rd_ack          = r_rd_ack;
  assign rd_underflow    = r_rd_underflow;

endmodule

// File: tb/tb_rd_ptr_status.sv
// Self-checking bench for rd_ptr_status (ADDRSIZE=4) against a word-count model.
module tb_rd_ptr_status;

  localparam int unsigned AS = 4;

  logic          rd_clk = 1'b0;
  logic          rd_rst = 1'b1;
  logic          rd_en = 1'b0;
  logic [AS:0]   rq2_wr_ptr = '0;
  logic [AS:0]   rd_ae_thresh = '0;
  logic          rd_underflow_clr = 1'b0;
  logic [AS-1:0] rd_addr;
  logic [AS:0]   rd_grayptr;
  logic          rd_empty;
  logic          rd_almost_empty;
  logic [AS:0]   rd_level;
  logic          rd_ack;
  logic          rd_underflow;

  rd_ptr_status #(.ADDRSIZE(AS)) dut (
    .rd_clk           (rd_clk),
    .rd_rst           (rd_rst),
    .rd_en            (rd_en),
    .rq2_wr_ptr       (rq2_wr_ptr),
    .rd_ae_thresh     (rd_ae_thresh),
    .rd_underflow_clr (rd_underflow_clr),
    .rd_addr          (rd_addr),
    .rd_grayptr       (rd_grayptr),
    .rd_empty         (rd_empty),
    .rd_almost_empty  (rd_almost_empty),
    .rd_level         (rd_level),
    .rd_ack           (rd_ack),
    .rd_underflow     (rd_underflow)
  );

  always #5 rd_clk = ~rd_clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Model: absolute words written (as seen through the synchroniser) and read.
  int unsigned wr_n = 0;
  int unsigned thr  = 0;
  int unsigned m_rd = 0;
  int          m_level = 0;
  bit          m_empty = 1, m_ae = 1, m_ack = 0, m_uf = 0;
  int unsigned max_level = 0;

  function automatic int unsigned gray_of(input int unsigned n);
    int unsigned m;
    m = n % 32;
    return m ^ (m >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, check after it.
  task automatic step(input bit en, input bit clr, input bit rst);
    bit acc;
    @(negedge rd_clk);
    rd_en            = en;
    rd_underflow_clr = clr;
    rd_rst           = rst;
    rq2_wr_ptr       = 5'(gray_of(wr_n));
    rd_ae_thresh     = 5'(thr);
    @(posedge rd_clk);
    if (rst) begin
      m_rd = 0; m_level = 0; m_empty = 1; m_ae = 1; m_ack = 0; m_uf = 0;
    end else begin
      acc = en && !m_empty;
      if (en && m_empty) m_uf = 1;
      else if (clr) m_uf = 0;
      m_rd    = m_rd + (acc ? 1 : 0);
      m_level = int'(wr_n) - int'(m_rd);
      m_empty = (m_level == 0);
      m_ae    = (m_level <= int'(thr));
      m_ack   = acc;
    end
    #1;
    chk("addr",      32'(rd_addr),         m_rd % 16);
    chk("grayptr",   32'(rd_grayptr),      gray_of(m_rd));
    chk("empty",     32'(rd_empty),        32'(m_empty));
    chk("alm_empty", 32'(rd_almost_empty), 32'(m_ae));
    chk("level",     32'(rd_level),        32'(m_level));
    chk("ack",       32'(rd_ack),          32'(m_ack));
    chk("underflow", 32'(rd_underflow),    32'(m_uf));
    if (32'(rd_level) > max_level) max_level = 32'(rd_level);
  endtask

  initial begin
    // Reset
    step(0, 0, 1);
    step(1, 1, 1);
    // Reads while empty: no ack, underflow sets
    wr_n = 0;
    thr  = 0;
    repeat (3) step(1, 0, 0);
    step(0, 1, 0);
    // Five words, threshold 2, continuous reads
    wr_n = 5;
    thr  = 2;
    step(0, 0, 0);
    repeat (6) step(1, 0, 0);
    chk("addr_end5", 32'(rd_addr), 32'd5);
    // Full FIFO with threshold 15 then 16
    wr_n = m_rd + 16;
    thr  = 15;
    step(0, 0, 0);
    chk("full_level", 32'(rd_level), 32'd16);
    thr = 16;
    step(0, 0, 0);
    chk("full_ae16", 32'(rd_almost_empty), 32'd1);
    // Drain, then underflow with simultaneous clear, then later clear
    for (int i = 0; i < 40 && m_level > 0; i++) step(1, 0, 0);
    step(1, 1, 0);
    chk("uf_set_wins", 32'(rd_underflow), 32'd1);
    step(0, 1, 0);
    // Wrap-around stream of 40 words, one Gray step at a time
    thr = 3;
    for (int i = 0; i < 40; i++) begin
      wr_n++;
      step(1, 0, 0);
    end
    repeat (3) step(1, 0, 0);
    // Randomized traffic with occasional clear and reset
    for (int i = 0; i < 400; i++) begin
      if (($urandom_range(0, 1) == 1) && (wr_n + 1 - m_rd <= 16)) wr_n++;
      thr = $urandom_range(0, 31);
      if ($urandom_range(0, 79) == 0) begin
        step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1);
        wr_n = 0;
      end else begin
        step(bit'($urandom_range(0, 3) != 0), $urandom_range(0, 7) == 0, 0);
      end
    end
    // Reset with level 7 and a read pending
    wr_n = m_rd + 7;
    thr  = 2;
    step(0, 0, 0);
    chk("pre_rst_level", 32'(rd_level), 32'd7);
    step(1, 1, 1);
    chk("rst_ack", 32'(rd_ack), 32'd0);
    wr_n = 0;
    step(0, 0, 0);
    chk("level_max", 32'(max_level <= 16), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
